// File: rtl/lane_clk_en_seq_if.sv
// Configuration port of lane_clk_en_seq: a single-cycle write of one channel's
// phase increment, optionally restarting that channel's reset sequence.
interface lane_clk_en_seq_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic              cfg_reseq;

    modport master (output cfg_wr, output cfg_ch, output cfg_inc, output cfg_reseq);
    modport slave  (input  cfg_wr, input  cfg_ch, input  cfg_inc, input  cfg_reseq);
endinterface

// File: rtl/lane_clk_en_seq.sv
// N-channel phase-accumulator clock-enable generator. Each channel holds its
// domain reset until it has seen RST_CYCLES ticks while running.
module lane_clk_en_seq #(
    parameter int              NUM_CH      = 4,
    parameter int              ACC_W       = 32,
    parameter int              RST_CYCLES  = 3,
    parameter logic [ACC_W-1:0] DEFAULT_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic               local_clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  ch_run,
    lane_clk_en_seq_if.slave   cfg,
    output logic [NUM_CH-1:0]  ch_tick,
    output logic [NUM_CH-1:0]  ch_rst,
    output logic               all_ready
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0] RST_TARGET = 8'(RST_CYCLES);

    typedef enum logic [1:0] {HOLD, COUNT, RELEASED} state_t;

    state_t            state     [NUM_CH];
    state_t            state_nxt [NUM_CH];
    logic [ACC_W-1:0]  acc       [NUM_CH];
    logic [ACC_W-1:0]  acc_nxt   [NUM_CH];
    logic [ACC_W-1:0]  inc       [NUM_CH];
    logic [ACC_W-1:0]  inc_nxt   [NUM_CH];
    logic [7:0]        count     [NUM_CH];
    logic [7:0]        count_nxt [NUM_CH];
    logic [7:0]        tally     [NUM_CH];
    logic [ACC_W:0]    sum       [NUM_CH];
    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] tick_nxt;
    logic              wr_valid;

    // The HOLD->COUNT edge already advances the accumulator, so a carry on
    // that edge counts toward release just like any later one.
    always_comb begin
        wr_valid = cfg.cfg_wr && (int'(cfg.cfg_ch) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i]       = {1'b0, acc[i]} + {1'b0, inc[i]};
            carry[i]     = ch_run[i] & sum[i][ACC_W];
            hit[i]       = wr_valid && (cfg.cfg_ch == CH_W'(i));
            tally[i]     = ((state[i] == HOLD) ? 8'd0 : count[i]) + {7'd0, carry[i]};
            acc_nxt[i]   = acc[i];
            inc_nxt[i]   = inc[i];
            count_nxt[i] = count[i];
            state_nxt[i] = state[i];
            tick_nxt[i]  = carry[i];

            if (ch_run[i])
                acc_nxt[i] = sum[i][ACC_W-1:0];

            case (state[i])
                HOLD, COUNT: begin
                    if (ch_run[i]) begin
                        count_nxt[i] = tally[i];
                        state_nxt[i] = (tally[i] == RST_TARGET) ? RELEASED : COUNT;
                    end else begin
                        count_nxt[i] = 8'd0;
                        state_nxt[i] = HOLD;
                    end
                end
                RELEASED: state_nxt[i] = RELEASED;
                default:  state_nxt[i] = HOLD;
            endcase

            // A re-sequence write overrides both the carry and any release.
            if (hit[i]) begin
                inc_nxt[i] = cfg.cfg_inc;
                if (cfg.cfg_reseq) begin
                    acc_nxt[i]   = '0;
                    count_nxt[i] = 8'd0;
                    state_nxt[i] = HOLD;
                    tick_nxt[i]  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge local_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= HOLD;
                acc[i]   <= '0;
                inc[i]   <= DEFAULT_INC;
                count[i] <= 8'd0;
            end
            ch_tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_nxt[i];
                acc[i]   <= acc_nxt[i];
                inc[i]   <= inc_nxt[i];
                count[i] <= count_nxt[i];
            end
            ch_tick <= tick_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            ch_rst[i] = (state[i] != RELEASED);
    end

    assign all_ready = &(~ch_rst);
endmodule

// File: tb/tb_lane_clk_en_seq.sv
// Randomised and directed bench for lane_clk_en_seq against a tick-counting
// reference model; a 3-channel copy checks that out-of-range writes are ignored.
module tb_lane_clk_en_seq;
    localparam int NUM_CH = 4;
    localparam int ACC_W  = 32;
    localparam int RST_N  = 3;
    localparam longint MOD = 64'h1_0000_0000;

    logic              local_clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_run;
    logic [NUM_CH-1:0] ch_tick, ch_rst;
    logic              all_ready;
    logic [2:0]        ch_tick3, ch_rst3;
    logic              all_ready3;

    int n_compared   = 0;
    int n_mismatched = 0;

    longint m_acc  [NUM_CH];
    longint m_inc  [NUM_CH];
    int     m_seen [NUM_CH];
    bit     m_rel  [NUM_CH];
    bit     m_tick [NUM_CH];

    always #5 local_clk = ~local_clk;

    lane_clk_en_seq_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg ();
    lane_clk_en_seq_if #(.NUM_CH(3), .ACC_W(ACC_W)) cfg3 ();

    assign cfg3.cfg_wr    = cfg.cfg_wr;
    assign cfg3.cfg_ch    = cfg.cfg_ch;
    assign cfg3.cfg_inc   = cfg.cfg_inc;
    assign cfg3.cfg_reseq = cfg.cfg_reseq;

    lane_clk_en_seq #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .RST_CYCLES(RST_N)) dut (
        .local_clk(local_clk), .rst(rst), .ch_run(ch_run), .cfg(cfg.slave),
        .ch_tick(ch_tick), .ch_rst(ch_rst), .all_ready(all_ready));

    lane_clk_en_seq #(.NUM_CH(3), .ACC_W(ACC_W), .RST_CYCLES(RST_N)) dut3 (
        .local_clk(local_clk), .rst(rst), .ch_run(ch_run[2:0]), .cfg(cfg3.slave),
        .ch_tick(ch_tick3), .ch_rst(ch_rst3), .all_ready(all_ready3));

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a channel releases once it has seen RST_N carries without
    // ch_run dropping; a valid re-sequence write starts it over from zero.
    task automatic modelStep(input bit i_rst, input logic [NUM_CH-1:0] i_run, input bit i_wr,
                             input int i_ch, input longint i_inc, input bit i_reseq);
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_rst) begin
                m_acc[i] = 0; m_inc[i] = 64'h8000_0000; m_seen[i] = 0; m_rel[i] = 0; m_tick[i] = 0;
            end else begin
                m_tick[i] = i_run[i] && (m_acc[i] + m_inc[i] >= MOD);
                if (i_run[i]) m_acc[i] = (m_acc[i] + m_inc[i]) % MOD;
                if (!m_rel[i]) begin
                    m_seen[i] = i_run[i] ? m_seen[i] + int'(m_tick[i]) : 0;
                    if (m_seen[i] >= RST_N) m_rel[i] = 1;
                end
                if (i_wr && i_ch == i && i_ch < NUM_CH) begin
                    m_inc[i] = i_inc;
                    if (i_reseq) begin
                        m_acc[i] = 0; m_seen[i] = 0; m_rel[i] = 0; m_tick[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit i_rst, input logic [NUM_CH-1:0] i_run, input bit i_wr,
                                 input int i_ch, input longint i_inc, input bit i_reseq);
        logic [NUM_CH-1:0] e_tick, e_rst;
        rst = i_rst; ch_run = i_run; cfg.cfg_wr = i_wr; cfg.cfg_ch = 2'(i_ch);
        cfg.cfg_inc = 32'(i_inc); cfg.cfg_reseq = i_reseq;
        @(posedge local_clk);
        modelStep(i_rst, i_run, i_wr, i_ch, i_inc, i_reseq);
        @(negedge local_clk);
        for (int i = 0; i < NUM_CH; i++) begin
            e_tick[i] = m_tick[i];
            e_rst[i]  = !m_rel[i];
        end
        checkOutput("ch_tick",    64'(ch_tick),    64'(e_tick));
        checkOutput("ch_rst",     64'(ch_rst),     64'(e_rst));
        checkOutput("all_ready",  64'(all_ready),  64'(e_rst == '0));
        checkOutput("ch_tick3",   64'(ch_tick3),   64'(e_tick[2:0]));
        checkOutput("ch_rst3",    64'(ch_rst3),    64'(e_rst[2:0]));
        checkOutput("all_ready3", 64'(all_ready3), 64'(e_rst[2:0] == '0));
    endtask

    task automatic idle(input logic [NUM_CH-1:0] i_run);
        applyStimulus(0, i_run, 0, 0, 0, 0);
    endtask

    initial begin
        int first_tick, rel_edge, ticks, last, gap_ok, ready_seen, guard;
        rst = 1; ch_run = '0; cfg.cfg_wr = 0; cfg.cfg_ch = '0; cfg.cfg_inc = '0; cfg.cfg_reseq = 0;

        // Quarter-rate increment: ticks every 4th edge, release on edge 12.
        applyStimulus(1, '0, 0, 0, 0, 0);
        applyStimulus(1, '0, 0, 0, 0, 0);
        for (int c = 0; c < NUM_CH; c++) applyStimulus(0, '0, 1, c, 64'h4000_0000, 0);
        first_tick = 0; rel_edge = 0;
        for (int e = 1; e <= 14; e++) begin
            idle('1);
            if (ch_tick[0] && first_tick == 0) first_tick = e;
            if (!ch_rst[0] && rel_edge == 0) rel_edge = e;
        end
        checkOutput("q_first_tick_edge", 64'(first_tick), 64'd4);
        checkOutput("q_release_edge",    64'(rel_edge),   64'd12);

        // Default half-rate increment: ticks on edges 2,4,6, release on 6.
        applyStimulus(1, '0, 0, 0, 0, 0);
        first_tick = 0; rel_edge = 0;
        for (int e = 1; e <= 8; e++) begin
            idle('1);
            if (ch_tick[1] && first_tick == 0) first_tick = e;
            if (!ch_rst[1] && rel_edge == 0) rel_edge = e;
        end
        checkOutput("h_first_tick_edge", 64'(first_tick), 64'd2);
        checkOutput("h_release_edge",    64'(rel_edge),   64'd6);

        // A zero-increment channel never releases, so all_ready stays low.
        applyStimulus(1, '0, 0, 0, 0, 0);
        applyStimulus(0, '0, 1, 3, 0, 0);
        ready_seen = 0;
        for (int e = 0; e < 1000; e++) begin
            idle('1);
            if (all_ready) ready_seen++;
        end
        checkOutput("zero_inc_ready_cycles", 64'(ready_seen), 64'd0);
        checkOutput("zero_inc_ch_rst3",      64'(ch_rst[3]),  64'd1);

        // One-third increment: exactly 100 ticks in 300 edges, spacing 2 or 3.
        applyStimulus(1, '0, 0, 0, 0, 0);
        for (int c = 0; c < NUM_CH; c++) applyStimulus(0, '0, 1, c, 64'h5555_5556, 0);
        ticks = 0; last = 0; gap_ok = 1;
        for (int e = 1; e <= 300; e++) begin
            idle('1);
            if (ch_tick[0]) begin
                if (last != 0 && (e - last < 2 || e - last > 3)) gap_ok = 0;
                last = e; ticks++;
            end
        end
        checkOutput("third_tick_count", 64'(ticks),  64'd100);
        checkOutput("third_gap_ok",     64'(gap_ok), 64'd1);

        // Channel 1 paused after two ticks must gather three fresh ones.
        applyStimulus(1, '0, 0, 0, 0, 0);
        for (int e = 0; e < 4; e++) idle('1);
        for (int e = 0; e < 5; e++) idle(4'b1101);
        checkOutput("paused_ch1_rst", 64'(ch_rst[1]), 64'd1);
        for (int e = 0; e < 8; e++) idle('1);
        checkOutput("resumed_ch1_rst", 64'(ch_rst[1]), 64'd0);

        // Re-sequence a released channel on an edge that would carry.
        guard = 0;
        while (m_acc[2] + m_inc[2] < MOD && guard < 16) begin idle('1); guard++; end
        checkOutput("reseq_carry_found", 64'(guard < 16), 64'd1);
        applyStimulus(0, '1, 1, 2, 64'h8000_0000, 1);
        checkOutput("reseq_no_tick",  64'(ch_tick[2]), 64'd0);
        checkOutput("reseq_rst_high", 64'(ch_rst[2]),  64'd1);
        checkOutput("reseq_not_ready", 64'(all_ready), 64'd0);
        for (int e = 0; e < 8; e++) idle('1);
        checkOutput("reseq_rereleased", 64'(ch_rst[2]), 64'd0);
        applyStimulus(0, '1, 1, 3, 0, 1);
        for (int e = 0; e < 4; e++) idle('1);
        checkOutput("oor_write_ready3", 64'(all_ready3), 64'd1);

        // Reset in the middle of counting clears everything at once.
        applyStimulus(1, '0, 0, 0, 0, 0);
        for (int e = 0; e < 3; e++) idle('1);
        applyStimulus(1, '1, 1, 0, 64'h1234_5678, 1);
        checkOutput("midrst_ch_rst",  64'(ch_rst),  64'hF);
        checkOutput("midrst_ch_tick", 64'(ch_tick), 64'h0);

        // Randomised traffic.
        for (int e = 0; e < 1500; e++) begin
            longint v;
            int sel;
            sel = int'($urandom_range(0, 3));
            v = (sel == 0) ? 64'h0 : (sel == 1) ? 64'h4000_0000 :
                (sel == 2) ? 64'h8000_0000 : longint'($urandom);
            applyStimulus($urandom_range(0, 63) == 0,
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                          $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), v,
                          $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
